// File: rtl/fwd_tracker.sv
// Operand forwarding and hazard tracker for the LC-3b pipeline.
// Resolves each decode source against NSTG in-flight producers and a small
// history of committed writes, raises stall on unready producers, counts
// stall cycles and flags a sticky watchdog error on long stall runs.

// Per-operand resolver: youngest stage match wins, then newest history entry.
module fwd_lane #(
  parameter int WIDTH = 16,
  parameter int NSTG  = 3,
  parameter int RB    = 3,
  parameter int HIST  = 2
) (
  input  logic                  src_valid_i,
  input  logic [RB-1:0]         src_reg_i,
  input  logic [WIDTH-1:0]      rf_data_i,
  input  logic [NSTG-1:0]       stg_valid_i,
  input  logic [NSTG-1:0]       stg_we_i,
  input  logic [NSTG*RB-1:0]    stg_dest_i,
  input  logic [NSTG*WIDTH-1:0] stg_data_i,
  input  logic [NSTG-1:0]       stg_rdy_i,
  input  logic [HIST-1:0]       hist_v_i,
  input  logic [HIST*RB-1:0]    hist_dest_i,
  input  logic [HIST*WIDTH-1:0] hist_data_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  hit_o,
  output logic                  stall_o
);

  logic             s_match, s_rdy, h_match;
  logic [WIDTH-1:0] s_data, h_data;

  // Scan oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    s_match = 1'b0;
    s_rdy   = 1'b0;
    s_data  = '0;
    for (int i = NSTG-1; i >= 0; i--) begin
      if (stg_valid_i[i] && stg_we_i[i] && (stg_dest_i[i*RB +: RB] == src_reg_i)) begin
        s_match = 1'b1;
        s_rdy   = stg_rdy_i[i];
        s_data  = stg_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Entry 0 is newest; scan from oldest so the newest match wins.
  always_comb begin
    h_match = 1'b0;
    h_data  = '0;
    for (int j = HIST-1; j >= 0; j--) begin
      if (hist_v_i[j] && (hist_dest_i[j*RB +: RB] == src_reg_i)) begin
        h_match = 1'b1;
        h_data  = hist_data_i[j*WIDTH +: WIDTH];
      end
    end
  end

  // An unready youngest producer blocks the operand; older values are stale.
  always_comb begin
    data_o  = rf_data_i;
    hit_o   = 1'b0;
    stall_o = 1'b0;
    if (src_valid_i) begin
      if (s_match) begin
        if (s_rdy) begin
          data_o = s_data;
          hit_o  = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end else if (h_match) begin
        data_o = h_data;
        hit_o  = 1'b1;
      end
    end
  end

endmodule

module fwd_tracker #(
  parameter int WIDTH     = 16,
  parameter int NSTG      = 3,
  parameter int NSRC      = 2,
  parameter int RB        = 3,
  parameter int HIST      = 2,
  parameter int MAX_STALL = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  advance_i,
  input  logic [NSTG-1:0]       stg_valid_i,
  input  logic [NSTG-1:0]       stg_we_i,
  input  logic [NSTG*RB-1:0]    stg_dest_i,
  input  logic [NSTG*WIDTH-1:0] stg_data_i,
  input  logic [NSTG-1:0]       stg_rdy_i,
  input  logic                  hist_clr_i,
  input  logic [NSRC-1:0]       src_valid_i,
  input  logic [NSRC*RB-1:0]    src_reg_i,
  input  logic [NSRC*WIDTH-1:0] rf_data_i,
  output logic [NSRC*WIDTH-1:0] fwd_data_o,
  output logic [NSRC-1:0]       fwd_hit_o,
  output logic                  stall_o,
  output logic [15:0]           stall_cnt_o,
  output logic                  hazard_err_o
);

  localparam int RW = $clog2(MAX_STALL+1);

  typedef enum logic [1:0] {S_RUN, S_STALLED, S_ERR} state_e;

  state_e                  state_q;
  logic [RW-1:0]           run_q;
  logic                    hazard_err_q;
  logic [15:0]             stall_cnt_q;
  logic [HIST-1:0]         hist_v_q, hist_v_d;
  logic [HIST*RB-1:0]      hist_dest_q, hist_dest_d;
  logic [HIST*WIDTH-1:0]   hist_data_q, hist_data_d;
  logic [NSRC-1:0]         lane_stall;
  logic                    commit;

  // Writeback only retires when the pipe actually shifts; a held stage
  // must not push the same write twice.
  assign commit = advance_i & stg_valid_i[NSTG-1] & stg_we_i[NSTG-1];

  for (genvar k = 0; k < NSRC; k++) begin : g_lane
    fwd_lane #(.WIDTH(WIDTH), .NSTG(NSTG), .RB(RB), .HIST(HIST)) u_lane (
      .src_valid_i (src_valid_i[k]),
      .src_reg_i   (src_reg_i[k*RB +: RB]),
      .rf_data_i   (rf_data_i[k*WIDTH +: WIDTH]),
      .stg_valid_i (stg_valid_i),
      .stg_we_i    (stg_we_i),
      .stg_dest_i  (stg_dest_i),
      .stg_data_i  (stg_data_i),
      .stg_rdy_i   (stg_rdy_i),
      .hist_v_i    (hist_v_q),
      .hist_dest_i (hist_dest_q),
      .hist_data_i (hist_data_q),
      .data_o      (fwd_data_o[k*WIDTH +: WIDTH]),
      .hit_o       (fwd_hit_o[k]),
      .stall_o     (lane_stall[k])
    );
  end

  assign stall_o      = |lane_stall;
  assign stall_cnt_o  = stall_cnt_q;
  assign hazard_err_o = hazard_err_q;

  // History next state: shift on commit, clear drops everything but a new commit.
  always_comb begin
    hist_v_d    = hist_v_q;
    hist_dest_d = hist_dest_q;
    hist_data_d = hist_data_q;
    if (commit) begin
      for (int i = HIST-1; i >= 1; i--) begin
        hist_v_d[i]                  = hist_v_q[i-1] & ~hist_clr_i;
        hist_dest_d[i*RB +: RB]      = hist_dest_q[(i-1)*RB +: RB];
        hist_data_d[i*WIDTH +: WIDTH] = hist_data_q[(i-1)*WIDTH +: WIDTH];
      end
      hist_v_d[0]           = 1'b1;
      hist_dest_d[RB-1:0]   = stg_dest_i[(NSTG-1)*RB +: RB];
      hist_data_d[WIDTH-1:0] = stg_data_i[(NSTG-1)*WIDTH +: WIDTH];
    end else if (hist_clr_i) begin
      hist_v_d = '0;
    end
  end

  // History registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_v_q    <= '0;
      hist_dest_q <= '0;
      hist_data_q <= '0;
    end else begin
      hist_v_q    <= hist_v_d;
      hist_dest_q <= hist_dest_d;
      hist_data_q <= hist_data_d;
    end
  end

  // Saturating count of every stalled cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Watchdog: tracks the length of the current stall run; ERR is sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_RUN;
      run_q        <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (stall_o) begin
            run_q <= RW'(1);
            if (MAX_STALL <= 1) begin
              state_q      <= S_ERR;
              hazard_err_q <= 1'b1;
            end else begin
              state_q <= S_STALLED;
            end
          end
        end
        S_STALLED: begin
          if (stall_o) begin
            run_q <= run_q + 1'b1;
            if (run_q >= RW'(MAX_STALL-1)) begin
              state_q      <= S_ERR;
              hazard_err_q <= 1'b1;
            end
          end else begin
            run_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_ERR: begin
          hazard_err_q <= 1'b1;
        end
        default: begin
          state_q <= S_RUN;
          run_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_tracker.sv
// Bench for fwd_tracker: directed scenarios then randomized traffic, all
// checked against a queue-based reference model of the forwarding rules.
module tb_fwd_tracker;

  localparam int WIDTH = 16, NSTG = 3, NSRC = 2, RB = 3, HIST = 2, MAX_STALL = 8;

  logic                  clk, rst, advance, hist_clr;
  logic [NSTG-1:0]       stg_valid, stg_we, stg_rdy;
  logic [NSTG*RB-1:0]    stg_dest;
  logic [NSTG*WIDTH-1:0] stg_data;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC*RB-1:0]    src_reg;
  logic [NSRC*WIDTH-1:0] rf_data;
  logic [NSRC*WIDTH-1:0] fwd_data;
  logic [NSRC-1:0]       fwd_hit;
  logic                  stall, hazard_err;
  logic [15:0]           stall_cnt;

  // bench-side stimulus arrays
  logic [RB-1:0]    sdest[NSTG];
  logic [WIDTH-1:0] sdata[NSTG];
  logic [RB-1:0]    xreg[NSRC];
  logic [WIDTH-1:0] xrf[NSRC];

  // reference model state
  logic [RB+WIDTH-1:0] hq[$];
  int m_cnt, m_run;
  bit m_err;
  int checks, failures;

  fwd_tracker #(.WIDTH(WIDTH), .NSTG(NSTG), .NSRC(NSRC), .RB(RB), .HIST(HIST),
                .MAX_STALL(MAX_STALL)) dut (
    .clk_i(clk), .rst_i(rst), .advance_i(advance), .stg_valid_i(stg_valid),
    .stg_we_i(stg_we), .stg_dest_i(stg_dest), .stg_data_i(stg_data),
    .stg_rdy_i(stg_rdy), .hist_clr_i(hist_clr), .src_valid_i(src_valid),
    .src_reg_i(src_reg), .rf_data_i(rf_data), .fwd_data_o(fwd_data),
    .fwd_hit_o(fwd_hit), .stall_o(stall), .stall_cnt_o(stall_cnt),
    .hazard_err_o(hazard_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    stg_dest = '0;
    stg_data = '0;
    src_reg  = '0;
    rf_data  = '0;
    for (int i = 0; i < NSTG; i++) begin
      stg_dest[i*RB +: RB]       = sdest[i];
      stg_data[i*WIDTH +: WIDTH] = sdata[i];
    end
    for (int k = 0; k < NSRC; k++) begin
      src_reg[k*RB +: RB]       = xreg[k];
      rf_data[k*WIDTH +: WIDTH] = xrf[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected combinational outputs from the forwarding rules.
  task automatic model_comb(output logic [NSRC*WIDTH-1:0] ed, output logic [NSRC-1:0] eh,
                            output logic es);
    bit found;
    ed = '0; eh = '0; es = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      ed[k*WIDTH +: WIDTH] = xrf[k];
      if (src_valid[k]) begin
        found = 0;
        for (int i = 0; i < NSTG; i++)
          if (!found && stg_valid[i] && stg_we[i] && sdest[i] == xreg[k]) begin
            found = 1;
            if (stg_rdy[i]) begin
              ed[k*WIDTH +: WIDTH] = sdata[i];
              eh[k] = 1'b1;
            end else es = 1'b1;
          end
        for (int j = 0; j < hq.size(); j++)
          if (!found && hq[j][RB+WIDTH-1:WIDTH] == xreg[k]) begin
            found = 1;
            ed[k*WIDTH +: WIDTH] = hq[j][WIDTH-1:0];
            eh[k] = 1'b1;
          end
      end
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_cnt = 0; m_run = 0; m_err = 0;
  endtask

  task automatic check_comb(input string tag);
    logic [NSRC*WIDTH-1:0] ed;
    logic [NSRC-1:0] eh;
    logic es;
    model_comb(ed, eh, es);
    chk({tag, "_data"}, 64'(fwd_data), 64'(ed));
    chk({tag, "_hit"}, 64'(fwd_hit), 64'(eh));
    chk({tag, "_stall"}, 64'(stall), 64'(es));
  endtask

  // One cycle: settle, check comb, clock, update model, check state.
  task automatic step(input string tag);
    logic [NSRC*WIDTH-1:0] ed;
    logic [NSRC-1:0] eh;
    logic es;
    bit com;
    #1;
    check_comb(tag);
    model_comb(ed, eh, es);
    com = advance && stg_valid[NSTG-1] && stg_we[NSTG-1];
    @(posedge clk);
    if (hist_clr) hq.delete();
    if (com) hq.push_front({sdest[NSTG-1], sdata[NSTG-1]});
    while (hq.size() > HIST) void'(hq.pop_back());
    if (es) begin
      if (m_cnt < 65535) m_cnt++;
      m_run++;
      if (m_run >= MAX_STALL) m_err = 1;
    end else m_run = 0;
    #1;
    chk({tag, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    chk({tag, "_err"}, 64'(hazard_err), 64'(m_err));
  endtask

  task automatic idle();
    stg_valid = '0; stg_we = '0; stg_rdy = '0;
    advance = 1'b0; hist_clr = 1'b0;
    for (int i = 0; i < NSTG; i++) begin sdest[i] = '0; sdata[i] = '0; end
  endtask

  task automatic set_stg(input int i, input logic [RB-1:0] d, input logic [WIDTH-1:0] v,
                         input logic r);
    stg_valid[i] = 1'b1; stg_we[i] = 1'b1; stg_rdy[i] = r;
    sdest[i] = d; sdata[i] = v;
  endtask

  task automatic commit(input logic [RB-1:0] d, input logic [WIDTH-1:0] v, input string tag);
    idle();
    set_stg(NSTG-1, d, v, 1'b1);
    advance = 1'b1;
    step(tag);
    idle();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    rst = 1'b1;
    idle();
    src_valid = 2'b11;
    xreg[0] = 3'd3; xreg[1] = 3'd5;
    xrf[0] = 16'h0AAA; xrf[1] = 16'h0BBB;
    #1;
    check_comb("reset");
    chk("reset_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_err", 64'(hazard_err), 64'd0);
    #11 rst = 1'b0;

    // youngest ready match beats an older one
    set_stg(0, 3'd3, 16'h1111, 1'b1);
    set_stg(2, 3'd3, 16'h2222, 1'b1);
    #1;
    chk("young_data", 64'(fwd_data[15:0]), 64'h1111);
    chk("young_hit", 64'(fwd_hit[0]), 64'd1);
    chk("young_stall", 64'(stall), 64'd0);
    step("young");

    // unready load stalls only when the operand is read
    idle();
    set_stg(1, 3'd5, 16'h5555, 1'b0);
    set_stg(2, 3'd5, 16'h6666, 1'b1);
    #1;
    chk("load_stall", 64'(stall), 64'd1);
    chk("load_hit", 64'(fwd_hit[1]), 64'd0);
    step("load");
    src_valid[1] = 1'b0;
    #1;
    chk("load_nosrc_stall", 64'(stall), 64'd0);
    step("load_nosrc");
    src_valid = 2'b11;

    // history keeps a committed value visible, then ages out
    commit(3'd2, 16'hABCD, "c_r2");
    xreg[0] = 3'd2; xrf[0] = 16'h0000;
    #1;
    chk("hist_data", 64'(fwd_data[15:0]), 64'hABCD);
    chk("hist_hit", 64'(fwd_hit[0]), 64'd1);
    step("hist");
    commit(3'd6, 16'h6006, "c_r6");
    commit(3'd7, 16'h7007, "c_r7");
    #1;
    chk("aged_hit", 64'(fwd_hit[0]), 64'd0);
    chk("aged_data", 64'(fwd_data[15:0]), 64'h0000);

    // held writeback stage does not push
    set_stg(NSTG-1, 3'd1, 16'h1001, 1'b1);
    advance = 1'b0;
    for (int c = 0; c < 3; c++) step("held");
    idle();
    xreg[0] = 3'd1; xreg[1] = 3'd6;
    #1;
    chk("held_r1_hit", 64'(fwd_hit[0]), 64'd0);
    chk("held_r6_hit", 64'(fwd_hit[1]), 64'd1);
    step("held_chk");

    // clear together with a commit keeps only the new entry
    idle();
    set_stg(NSTG-1, 3'd4, 16'h4004, 1'b1);
    advance = 1'b1; hist_clr = 1'b1;
    step("clr_commit");
    idle();
    xreg[0] = 3'd4; xreg[1] = 3'd7;
    #1;
    chk("clr_r4_hit", 64'(fwd_hit[0]), 64'd1);
    chk("clr_r7_hit", 64'(fwd_hit[1]), 64'd0);
    step("clr_chk");
    hist_clr = 1'b1;
    step("clr_only");
    hist_clr = 1'b0;
    #1;
    chk("clr_only_hit", 64'(fwd_hit[0]), 64'd0);

    // watchdog
    do_reset();
    idle();
    xreg[1] = 3'd5;
    set_stg(0, 3'd5, 16'h5555, 1'b0);
    for (int c = 0; c < MAX_STALL; c++) begin
      if (c == MAX_STALL-1) chk("wd_pre_err", 64'(hazard_err), 64'd0);
      step("wd");
    end
    chk("wd_err", 64'(hazard_err), 64'd1);
    chk("wd_cnt", 64'(stall_cnt), 64'd8);
    idle();
    step("wd_rel");
    step("wd_rel");
    chk("wd_sticky", 64'(hazard_err), 64'd1);

    // reset in the middle of a stall run
    do_reset();
    commit(3'd2, 16'hBEEF, "rs_c");
    xreg[0] = 3'd2;
    set_stg(1, 3'd5, 16'h5555, 1'b0);
    for (int c = 0; c < 5; c++) step("rs_stall");
    chk("rs_cnt5", 64'(stall_cnt), 64'd5);
    #2 rst = 1'b1;
    idle();
    model_reset();
    #1;
    chk("rs_cnt0", 64'(stall_cnt), 64'd0);
    chk("rs_err0", 64'(hazard_err), 64'd0);
    chk("rs_hist_miss", 64'(fwd_hit[0]), 64'd0);
    check_comb("rs_comb");
    #1 rst = 1'b0;

    // randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSTG; i++) begin
        stg_valid[i] = ($urandom_range(0, 3) != 0);
        stg_we[i]    = ($urandom_range(0, 3) != 0);
        stg_rdy[i]   = ($urandom_range(0, 4) != 0);
        sdest[i]     = RB'($urandom_range(0, 7));
        sdata[i]     = WIDTH'($urandom);
      end
      for (int k = 0; k < NSRC; k++) begin
        src_valid[k] = ($urandom_range(0, 3) != 0);
        xreg[k]      = RB'($urandom_range(0, 7));
        xrf[k]       = WIDTH'($urandom);
      end
      advance  = ($urandom_range(0, 2) != 0);
      hist_clr = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_tracker.md
Name: fwd_tracker

Overview:
- Parametrised operand-forwarding and hazard unit for the LC-3b pipeline; successor to the fixed two-stage MEM/WB forwarding selector.
- Resolves the newest value of each decode-stage source register across NSTG in-flight producer stages.
- Holds a history buffer of recently committed writes so values stay visible through the register-file write-to-read gap and through decode freezes.
- Detects not-yet-ready producers (loads, TRAP reads), raises a stall, and counts stall cycles with a watchdog.

Parameters:
WIDTH, 16, data word width
NSTG, 3, number of producer stages; stage 0 is youngest, stage NSTG-1 is the writeback stage
NSRC, 2, number of source operands resolved per cycle
RB, 3, register index width
HIST, 2, number of committed-write history entries (1..4)
MAX_STALL, 8, consecutive stall cycles before watchdog error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
advance  in  1  pipeline stages shift this cycle
stg_valid  in  NSTG  stage holds a live instruction
stg_we  in  NSTG  stage instruction writes a register
stg_dest  in  NSTG*RB  destination register per stage
stg_data  in  NSTG*WIDTH  result per stage (already opcode-selected upstream)
stg_rdy  in  NSTG  stage result is final
hist_clr  in  1  synchronous clear of history
src_valid  in  NSRC  operand is actually read
src_reg  in  NSRC*RB  source register per operand
rf_data  in  NSRC*WIDTH  register-file read data per operand
fwd_data  out  NSRC*WIDTH  resolved operand value
fwd_hit  out  NSRC  value came from a stage or the history buffer
stall  out  1  decode must hold
stall_cnt  out  16  total stall cycles, saturating
hazard_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, active-high): all history entries invalid, stall_cnt=0, hazard_err=0, FSM in RUN. fwd_data, fwd_hit and stall are combinational; while rst is high and stages are idle, fwd_data=rf_data and fwd_hit=0.
- Producer match for operand k: stage i with stg_valid[i] & stg_we[i] & stg_dest[i]==src_reg[k]. Only the youngest (lowest i) match counts. R0 is an ordinary register.
- If the youngest stage match has stg_rdy=1: fwd_data[k]=stg_data[i], fwd_hit[k]=1.
- If the youngest stage match has stg_rdy=0: stall asserts, fwd_data[k]=rf_data[k], fwd_hit[k]=0. Older ready matches are never used in its place.
- With no stage match, the newest valid history entry with matching dest supplies the data (fwd_hit=1). Otherwise fwd_data=rf_data, fwd_hit=0.
- If src_valid[k]=0: fwd_hit[k]=0, operand k does not contribute to stall, fwd_data[k]=rf_data[k].
- Per-operand decisions are independent. stall is the OR across operands.
- Zero latency from any input to fwd_data, fwd_hit or stall.
- Commit occurs when advance & stg_valid[NSTG-1] & stg_we[NSTG-1].
  - On commit, {dest,data} is written to history entry 0 and entries shift toward HIST-1; the oldest entry drops.
  - No commit when advance=0: the stage is held, so there is no duplicate push.
- hist_clr alone invalidates all entries at the next edge.
- hist_clr together with commit: all entries are cleared except entry 0, which takes the new commit.
- stall_cnt increments on every cycle with stall=1 and saturates at 16'hFFFF.
- FSM:
  - RUN: on stall=1, go to STALLED with run=1.
  - STALLED: stall=1 increments run; reaching MAX_STALL goes to ERR. stall=0 returns to RUN with run=0.
  - ERR: sets hazard_err=1, held until reset. Forwarding and counting continue normally in ERR.
- Reset mid-stall: FSM returns to RUN, run=0, history is lost, stall_cnt=0.

Test Plan:
- Stage0 dest=R3 data=16'h1111 rdy=1, stage2 dest=R3 data=16'h2222, src0=R3 -> fwd_data0=16'h1111, fwd_hit0=1, stall=0.
- Stage1 load dest=R5 rdy=0, src1=R5, src_valid1=1 -> stall=1, fwd_hit1=0. Same with src_valid1=0 -> stall=0.
- Commit R2=16'hABCD with advance=1, then all stages idle, src0=R2, rf_data0=16'h0000 -> fwd_data0=16'hABCD, fwd_hit0=1. After HIST further commits to other registers, R2 reads rf_data.
- Commit with advance=0 for 3 cycles -> exactly zero history pushes. hist_clr together with a commit of R4 -> only R4 hits.
- Hold an unready match for MAX_STALL cycles -> hazard_err=1 on that edge, stall_cnt=8. Release stall -> hazard_err stays 1 until rst.
- Assert rst mid-stall at stall_cnt=5 -> stall_cnt=0, hazard_err=0, history misses immediately, without waiting for a clock edge.
